// File: rtl/uart_rx_frame_if.sv
// Receiver-side bundle: serial line in, word/flag handshake out, consumer controls back in.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rxd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun_err;
  logic                 err_clr;
  logic                 rx_busy;

  modport master (
    input  uart_rxd, rx_ready, err_clr,
    output rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );

  modport slave (
    output uart_rxd, rx_ready, err_clr,
    input  rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: majority-sampled bits, optional parity, 1/2 stop bits,
// valid/ready word output with per-frame parity/framing flags and sticky overrun.
module uart_rx_frame #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic             clk,
  input logic             rst,
  uart_rx_frame_if.master bus
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CNT_W   = $clog2(BPS_CNT);
  localparam int MID     = BPS_CNT / 2;
  localparam int IDX_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_f_q, perr_f_d, ferr_f_q, ferr_f_d;
  logic                 done_q, done_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;

  logic start_edge, maj, at_dec, accept;

  assign start_edge = rxd_s3_q & ~rxd_s2_q;
  // Third sample is the live synchronised value at MID+1; the first two were captured earlier.
  assign maj    = (samp_a_q & samp_b_q) | (samp_a_q & rxd_s2_q) | (samp_b_q & rxd_s2_q);
  assign at_dec = (cnt_q == CNT_W'(MID + 1));
  assign accept = valid_q & bus.rx_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    samp_a_d   = samp_a_q;
    samp_b_d   = samp_b_q;
    shift_d    = shift_q;
    perr_f_d   = perr_f_q;
    ferr_f_d   = ferr_f_q;
    done_d     = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == CNT_W'(BPS_CNT - 1)) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_W'(MID - 1)) samp_a_d = rxd_s2_q;
      if (cnt_q == CNT_W'(MID))     samp_b_d = rxd_s2_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = S_START;
      end
      S_START: if (at_dec) begin
        if (maj) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_DATA;
          idx_d    = '0;
          perr_f_d = 1'b0;
          ferr_f_d = 1'b0;
        end
      end
      S_DATA: if (at_dec) begin
        shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
          state_d    = (PARITY != 0) ? S_PARITY : S_STOP;
          stop_idx_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_PARITY: if (at_dec) begin
        perr_f_d   = ((^shift_q) ^ maj) != (PARITY == 1);
        state_d    = S_STOP;
        stop_idx_d = 1'b0;
      end
      S_STOP: if (at_dec) begin
        if (!maj) ferr_f_d = 1'b1;
        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (bus.err_clr) ovr_d = 1'b0;
    // A completing frame takes the slot if it is free or being vacated this cycle.
    if (done_q) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = perr_f_q;
        ferr_d  = ferr_f_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_s3_q   <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      samp_a_q   <= 1'b1;
      samp_b_q   <= 1'b1;
      shift_q    <= '0;
      perr_f_q   <= 1'b0;
      ferr_f_q   <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rxd_s1_q   <= bus.uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_s3_q   <= rxd_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      samp_a_q   <= samp_a_d;
      samp_b_q   <= samp_b_d;
      shift_q    <= shift_d;
      perr_f_q   <= perr_f_d;
      ferr_f_q   <= ferr_f_d;
      done_q     <= done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.rx_data     = data_q;
  assign bus.rx_valid    = valid_q;
  assign bus.parity_err  = perr_q;
  assign bus.frame_err   = ferr_q;
  assign bus.overrun_err = ovr_q;
  assign bus.rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Three receiver configurations (8N1, 8E1, 7N2) checked every cycle against a frame-level model.
module tb_uart_rx_frame;

  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NCH-1:0] rxd = '1;
  logic [NCH-1:0] rdy = '1;
  logic [NCH-1:0] clr = '0;

  wire [NCH-1:0] o_valid, o_perr, o_ferr, o_ovr, o_busy;
  wire [8:0]     o_data [NCH];

  int cfg_db  [NCH] = '{8, 8, 7};
  int cfg_par [NCH] = '{0, 2, 0};
  int cfg_sb  [NCH] = '{1, 1, 2};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int DB = (g == 2) ? 7 : 8;
    localparam int PB = (g == 1) ? 2 : 0;
    localparam int SB = (g == 2) ? 2 : 1;
    uart_rx_frame_if #(.DATA_BITS(DB)) bus ();
    uart_rx_frame #(
      .CLK_FREQ (1000000),
      .UART_BPS (100000),
      .DATA_BITS(DB),
      .PARITY   (PB),
      .STOP_BITS(SB)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.uart_rxd = rxd[g];
    assign bus.rx_ready = rdy[g];
    assign bus.err_clr  = clr[g];
    assign o_valid[g]   = bus.rx_valid;
    assign o_data[g]    = 9'(bus.rx_data);
    assign o_perr[g]    = bus.parity_err;
    assign o_ferr[g]    = bus.frame_err;
    assign o_ovr[g]     = bus.overrun_err;
    assign o_busy[g]    = bus.rx_busy;
  end

  typedef struct {
    int         ch;
    int         at;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } ev_t;

  ev_t        evq [$];
  int         cyc = 0;
  int         bs [NCH] = '{0, 0, 0};
  int         be [NCH] = '{0, 0, 0};
  logic       m_valid [NCH];
  logic [8:0] m_data  [NCH];
  logic       m_perr  [NCH];
  logic       m_ferr  [NCH];
  logic       m_ovr   [NCH];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int ch, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d @cyc %0d: got %h expected %h", name, ch, cyc, act, exp);
    end
  endtask

  // Frame-level model: completion lands 10 clocks per bit after the first posedge that sees the start bit.
  task automatic send_frame(input int ch, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
    logic [12:0] bits;
    int          n;
    int          s;
    logic        x;
    ev_t         e;
    bits   = '0;
    n      = 1;
    x      = 1'b0;
    e.data = '0;
    e.perr = 1'b0;
    e.ferr = 1'b0;
    for (int i = 0; i < cfg_db[ch]; i++) begin
      bits[n]   = data[i];
      e.data[i] = data[i];
      x         = x ^ data[i];
      n++;
    end
    if (cfg_par[ch] != 0) begin
      bits[n] = pbit;
      n++;
      e.perr = ((x ^ pbit) != (cfg_par[ch] == 1));
    end
    for (int i = 0; i < cfg_sb[ch]; i++) begin
      bits[n] = stops[i];
      if (!stops[i]) e.ferr = 1'b1;
      n++;
    end
    s      = cyc + 1;
    e.ch   = ch;
    e.at   = s + 10 * n;
    evq.push_back(e);
    bs[ch] = s + 2;
    be[ch] = s + 10 * n - 1;
    for (int b = 0; b < n; b++) begin
      rxd[ch] = bits[b];
      repeat (10) @(negedge clk);
    end
    rxd[ch] = 1'b1;
  endtask

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      m_valid[ch] = 1'b0; m_data[ch] = '0; m_perr[ch] = 1'b0; m_ferr[ch] = 1'b0; m_ovr[ch] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        evq.delete();
        for (int ch = 0; ch < NCH; ch++) begin
          m_valid[ch] = 1'b0; m_data[ch] = '0; m_perr[ch] = 1'b0; m_ferr[ch] = 1'b0; m_ovr[ch] = 1'b0;
          bs[ch] = 0; be[ch] = 0;
        end
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          logic evt, acc;
          ev_t  e;
          evt = 1'b0;
          if (evq.size() > 0 && evq[0].ch == ch && evq[0].at == cyc) begin
            e   = evq.pop_front();
            evt = 1'b1;
          end
          acc = m_valid[ch] && rdy[ch];
          if (clr[ch]) m_ovr[ch] = 1'b0;
          if (evt) begin
            if (!m_valid[ch] || acc) begin
              m_valid[ch] = 1'b1; m_data[ch] = e.data; m_perr[ch] = e.perr; m_ferr[ch] = e.ferr;
            end else begin
              m_ovr[ch] = 1'b1;
            end
          end else if (acc) begin
            m_valid[ch] = 1'b0; m_perr[ch] = 1'b0; m_ferr[ch] = 1'b0;
          end
        end
      end
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
        chk("valid", ch, 9'(o_valid[ch]), 9'(m_valid[ch]));
        chk("data",  ch, o_data[ch], m_data[ch]);
        chk("perr",  ch, 9'(o_perr[ch]), 9'(m_perr[ch]));
        chk("ferr",  ch, 9'(o_ferr[ch]), 9'(m_ferr[ch]));
        chk("ovr",   ch, 9'(o_ovr[ch]), 9'(m_ovr[ch]));
        chk("busy",  ch, 9'(o_busy[ch]), 9'(cyc >= bs[ch] && cyc < be[ch]));
      end
    end
  end

  initial begin
    int s;
    int target;
    repeat (3) @(negedge clk);
    chk("rst_valid", 0, 9'(o_valid[0]), 9'd0);
    chk("rst_busy",  0, 9'(o_busy[0]), 9'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_frame(0, 9'h0A5, 1'b0, 2'b11);
    @(negedge clk);
    chk("t1_valid", 0, 9'(o_valid[0]), 9'd1);
    chk("t1_data",  0, o_data[0], 9'h0A5);
    chk("t1_flags", 0, {6'd0, o_perr[0], o_ferr[0], o_ovr[0]}, 9'd0);
    @(negedge clk);
    chk("t1_drop",  0, 9'(o_valid[0]), 9'd0);

    send_frame(1, 9'h03C, 1'b1, 2'b11);
    @(negedge clk);
    chk("t2_data", 1, o_data[1], 9'h03C);
    chk("t2_perr", 1, 9'(o_perr[1]), 9'd1);
    send_frame(1, 9'h03C, 1'b0, 2'b11);
    @(negedge clk);
    chk("t2b_valid", 1, 9'(o_valid[1]), 9'd1);
    chk("t2b_perr",  1, 9'(o_perr[1]), 9'd0);

    send_frame(2, 9'h055, 1'b0, 2'b01);
    @(negedge clk);
    chk("t3_data", 2, o_data[2], 9'h055);
    chk("t3_ferr", 2, 9'(o_ferr[2]), 9'd1);
    repeat (5) @(negedge clk);

    s = cyc + 1;
    bs[0] = s + 2;
    be[0] = s + 9;
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_busy_hi", 0, 9'(o_busy[0]), 9'd1);
    repeat (4) @(negedge clk);
    chk("t4_busy_lo", 0, 9'(o_busy[0]), 9'd0);
    repeat (100) @(negedge clk);
    chk("t4_novalid", 0, 9'(o_valid[0]), 9'd0);

    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11);
    send_frame(0, 9'h022, 1'b0, 2'b11);
    @(negedge clk);
    chk("t5_valid", 0, 9'(o_valid[0]), 9'd1);
    chk("t5_data",  0, o_data[0], 9'h011);
    chk("t5_ovr",   0, 9'(o_ovr[0]), 9'd1);
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_acc",   0, 9'(o_valid[0]), 9'd0);
    chk("t5_stick", 0, 9'(o_ovr[0]), 9'd1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    @(negedge clk);
    chk("t5_clr", 0, 9'(o_ovr[0]), 9'd0);

    rdy[0] = 1'b0;
    target = cyc + 1 + 200;
    fork
      begin
        send_frame(0, 9'h044, 1'b0, 2'b11);
        send_frame(0, 9'h055, 1'b0, 2'b11);
      end
      begin
        while (cyc != target - 1) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
      end
    join
    chk("t5_setwins", 0, 9'(o_ovr[0]), 9'd1);
    chk("t5_keep",    0, o_data[0], 9'h044);
    rdy[0] = 1'b1;
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    repeat (5) @(negedge clk);

    s = cyc + 1;
    bs[0] = s + 2;
    be[0] = s + 100000;
    rxd[0] = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd[0] = 1'b0;
      repeat (10) @(negedge clk);
    end
    rxd[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", 0, 9'(o_busy[0]), 9'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_out", 0, {3'd0, o_valid[0], o_perr[0], o_ferr[0], o_ovr[0], o_busy[0], 1'b0}, 9'd0);
    chk("t6_rst_data", 0, o_data[0], 9'h000);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(0, 9'h05A, 1'b0, 2'b11);
    @(negedge clk);
    chk("t6_data",  0, o_data[0], 9'h05A);
    chk("t6_flags", 0, {6'd0, o_perr[0], o_ferr[0], o_ovr[0]}, 9'd0);

    repeat (20) @(negedge clk);
    chk("drained", 0, 9'(evq.size()), 9'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
